// File: rtl/tlut_temporal_cmp_if.sv
// ---------------------------------------------------------------------------
// tlut_temporal_cmp_if
// Handshake and data bundle between the operand buffer / adder-tree side
// (master) and the temporal comparator (slave).
//   start     master->slave  request a new sweep (taken only while in_ready)
//   mode      master->slave  0 = equality pulse, 1 = thermometer
//   enable    master->slave  sweep advance; low stalls the sweep
//   in        master->slave  DIM_A operands of INPUT_WIDTH bits
//   in_ready  slave->master  comparator idle, start will be accepted
//   busy      slave->master  sweep in progress
//   cnt_out   slave->master  counter value of the current beat
//   cmp_out   slave->master  per-channel compare bits of the current beat
//   cmp_valid slave->master  cnt_out/cmp_out hold a valid beat
//   hit_mask  slave->master  sticky per-channel equality-seen flags
//   done      slave->master  one-cycle pulse with the final beat
// ---------------------------------------------------------------------------
interface tlut_temporal_cmp_if #(
   parameter int INPUT_WIDTH = 8,
   parameter int DIM_A       = 16
);
   logic                                 start;
   logic                                 mode;
   logic                                 enable;
   logic [DIM_A-1:0][INPUT_WIDTH-1:0]    in;
   logic                                 in_ready;
   logic                                 busy;
   logic [INPUT_WIDTH-1:0]               cnt_out;
   logic [DIM_A-1:0]                     cmp_out;
   logic                                 cmp_valid;
   logic [DIM_A-1:0]                     hit_mask;
   logic                                 done;

   modport master (
      output start, mode, enable, in,
      input  in_ready, busy, cnt_out, cmp_out, cmp_valid, hit_mask, done
   );

   modport slave (
      input  start, mode, enable, in,
      output in_ready, busy, cnt_out, cmp_out, cmp_valid, hit_mask, done
   );
endinterface

// File: rtl/tlut_temporal_cmp.sv
// ---------------------------------------------------------------------------
// tlut_temporal_cmp
// Self-timed temporal comparator for the temporal-LUT multiplier datapath.
// On an accepted start it latches DIM_A operands and a compare mode, then
// sweeps an internal counter 0..SWEEP_LEN-1, one step per enabled cycle.
// Each enabled step emits a registered beat: per-channel equality pulses
// (in==cnt) or thermometer bits (in>cnt), plus the counter value the beat
// belongs to. Equality hits are accumulated into a sticky hit mask.
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active low
//   bus    tlut_temporal_cmp_if slave modport (handshake, operands, beats)
// ---------------------------------------------------------------------------
module tlut_temporal_cmp #(
   parameter int INPUT_WIDTH = 8,
   parameter int DIM_A       = 16,
   parameter int SWEEP_LEN   = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tlut_temporal_cmp_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Terminal count. With SWEEP_LEN == 2**INPUT_WIDTH this is all ones, so
   // the counter stops on it instead of wrapping before DONE.
   localparam logic [INPUT_WIDTH-1:0] C_LAST = INPUT_WIDTH'(SWEEP_LEN - 1);

   state_t                               r_state;
   logic [INPUT_WIDTH-1:0]               r_cnt;
   logic [DIM_A-1:0][INPUT_WIDTH-1:0]    r_inQ;
   logic                                 r_modeQ;
   logic [INPUT_WIDTH-1:0]               r_cntOut;
   logic [DIM_A-1:0]                     r_cmpOut;
   logic                                 r_cmpValid;
   logic [DIM_A-1:0]                     r_hitMask;

   logic [DIM_A-1:0]                     w_eq;
   logic [DIM_A-1:0]                     w_gt;

   // Per-channel unsigned compares of the latched operands against the
   // current counter value.
   always_comb begin
      w_eq = '0;
      w_gt = '0;
      for (int i = 0; i < DIM_A; i++) begin
         w_eq[i] = (r_inQ[i] == r_cnt);
         w_gt[i] = (r_inQ[i] >  r_cnt);
      end
   end

   // Sweep controller. A stalled cycle drops cmp_valid but keeps the last
   // beat, counter and hit mask. The hit mask is only cleared by the next
   // accepted start so it stays readable after done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_inQ      <= '0;
         r_modeQ    <= 1'b0;
         r_cntOut   <= '0;
         r_cmpOut   <= '0;
         r_cmpValid <= 1'b0;
         r_hitMask  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_inQ     <= bus.in;
                  r_modeQ   <= bus.mode;
                  r_cnt     <= '0;
                  r_hitMask <= '0;
                  r_state   <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               if (bus.enable) begin
                  r_cmpOut   <= r_modeQ ? w_gt : w_eq;
                  r_cntOut   <= r_cnt;
                  r_cmpValid <= 1'b1;
                  r_hitMask  <= r_hitMask | w_eq;
                  if (r_cnt == C_LAST) begin
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + INPUT_WIDTH'(1);
                  end
               end else begin
                  r_cmpValid <= 1'b0;
               end
            end
            S_DONE: begin
               r_cmpValid <= 1'b0;
               r_cmpOut   <= '0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.cnt_out   = r_cntOut;
   assign bus.cmp_out   = r_cmpOut;
   assign bus.cmp_valid = r_cmpValid;
   assign bus.hit_mask  = r_hitMask;

endmodule
